// File: rtl/sha256_msg_schedule_if.sv
// Word-stream bundle for the SHA-256 message schedule: serial input words
// and the valid/ready schedule-word output.
interface sha256_msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, emits W[0..ROUNDS-1] one per handshake.
// Optional SHA256_SCHED_IDX_OUT_EN adds out_idx (index t of the word on out_word).
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS    = 64,
  parameter int unsigned BLK_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  sha256_msg_schedule_if.slave   bus,
  output logic                   done
`ifdef SHA256_SCHED_IDX_OUT_EN
  ,
  output logic [5:0]             out_idx
`endif
);

  typedef enum logic {LOAD, EMIT} state_e;

  localparam logic [5:0] LAST_LOAD = 6'(BLK_WORDS - 1);
  localparam logic [5:0] LAST_EMIT = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] w_q [BLK_WORDS];
  logic [31:0] w_d [BLK_WORDS];
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;

  logic        in_fire;
  logic        out_fire;
  logic [31:0] w_next;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign in_fire  = (state_q == LOAD) && in_ready_q && bus.in_valid;
  assign out_fire = (state_q == EMIT) && out_valid_q && bus.out_ready;

  // Window slot 0 holds W[t]; the new tail word is W[t+16].
  assign w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    for (int unsigned i = 0; i < BLK_WORDS; i++) begin
      w_d[i] = w_q[i];
    end

    case (state_q)
      LOAD: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_fire) begin
          for (int unsigned i = 0; i < BLK_WORDS; i++) begin
            if (cnt_q[3:0] == 4'(i)) begin
              w_d[i] = bus.in_word;
            end
          end
          if (cnt_q == LAST_LOAD) begin
            cnt_d       = '0;
            state_d     = EMIT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      EMIT: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (out_fire) begin
          for (int unsigned i = 0; i < BLK_WORDS - 1; i++) begin
            w_d[i] = w_q[i + 1];
          end
          w_d[BLK_WORDS - 1] = w_next;
          if (cnt_q == LAST_EMIT) begin
            cnt_d       = '0;
            state_d     = LOAD;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    // Flush overrides any same-cycle handshake: the window write is dropped too.
    if (flush) begin
      state_d     = LOAD;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      for (int unsigned i = 0; i < BLK_WORDS; i++) begin
        w_d[i] = w_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < BLK_WORDS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      for (int unsigned i = 0; i < BLK_WORDS; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = w_q[0];
  assign done          = done_q;

`ifdef SHA256_SCHED_IDX_OUT_EN
  assign out_idx = out_valid_q ? cnt_q : '0;
`endif

endmodule
